tlk2711_rx_sched: RTL and testbench
===================================

// Module: tlk2711_rx_sched
// PURPOSE
//  Buffer-ring scheduler for tlk2711_rx_link. Holds NUM_BUF DDR base addresses, arms the link
//  with the next free buffer (rx_start + base), waits for the packet-complete interrupt, posts
//  a completion record to software, and advances. On loss interrupt or timeout it pulses the
//  link soft reset and re-arms. Sits between the PS register block and tlk2711_rx_link.
// PARAMETERS
//  ADDR_WIDTH  32   DDR byte-address width
//  NUM_BUF     4    ring depth, power of 2, 2..16
//  IDX_W       2    log2(NUM_BUF)
//  TMO_W       24   watchdog counter width; timeout = 2**TMO_W-1 cycles in WAIT
//  RST_CYC     16   soft-reset pulse length in cycles
// PORTS
//  clk               in   1           system clock
//  rst_n             in   1           asynchronous active-low reset
//  i_enable          in   1           SW run enable; 0 = stop after current packet
//  i_cfg_we          in   1           write base-address table entry
//  i_cfg_idx         in   IDX_W       table index
//  i_cfg_addr        in   ADDR_WIDTH  base address, bits[2:0] ignored (forced 0)
//  i_release         in   1           SW returns a consumed buffer
//  i_release_idx     in   IDX_W       buffer being returned
//  o_rx_start        out  1           1-cycle pulse to rx_link
//  o_rx_base_addr    out  ADDR_WIDTH  valid with and held after o_rx_start
//  i_rx_interrupt    in   1           packet complete from rx_link
//  i_rx_total_packet in   32          total bytes, sampled on i_rx_interrupt
//  i_rx_body_num     in   16          frame count, sampled on i_rx_interrupt
//  i_loss_interrupt  in   1           sync/link loss pulse
//  o_soft_rst        out  1           soft reset to rx_link
//  o_done_valid      out  1           completion record valid (valid/ready)
//  i_done_ready      in   1           SW accepts record
//  o_done_idx        out  IDX_W       buffer index of record
//  o_done_len        out  32          bytes in buffer
//  o_done_frames     out  16          frames in buffer
//  o_done_err        out  1           1 = aborted (loss/timeout), len/frames = 0
//  o_free_cnt        out  IDX_W+1     free buffers
//  o_busy            out  1           state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; free bitmap all 1 (o_free_cnt = NUM_BUF); head ptr 0; table 0.
//  FSM IDLE -> ARM -> WAIT -> POST -> IDLE; any of ARM/WAIT -> RECOV -> POST.
//   IDLE : i_enable & free[head] -> ARM. Else stay.
//   ARM  : o_rx_start=1 one cycle, o_rx_base_addr=table[head]; clear free[head]; -> WAIT.
//   WAIT : watchdog counts from 0. i_rx_interrupt -> latch len/frames, err=0, -> POST.
//          i_loss_interrupt or watchdog all-ones -> RECOV. Interrupt wins if same cycle as loss.
//   RECOV: o_soft_rst=1 for RST_CYC cycles, err=1, len=frames=0 -> POST.
//   POST : o_done_valid=1, fields stable until i_done_ready; on handshake head<=head+1
//          (wraps NUM_BUF-1 -> 0), -> IDLE. Latency interrupt->o_done_valid = 1 cycle.
//  Record for errored buffer: free[idx] is NOT set; SW must release it like a good one.
//  i_release sets free[idx]; release of an already-free idx is ignored (no count change).
//  Release and ARM on same idx same cycle: ARM clear wins (idx cannot be both; SW error).
//  o_free_cnt = popcount(free), registered, updated the cycle after any change.
//  i_cfg_we allowed any time; write to table[head] during WAIT does not affect the armed addr
//  (o_rx_base_addr is a register loaded in ARM).
//  i_enable drop: WAIT completes normally; FSM then stays in IDLE.
//  i_rx_interrupt outside WAIT is ignored. i_loss_interrupt outside ARM/WAIT ignored.
//  Ring full (no free at head): FSM holds IDLE; never skips head to find another buffer.
//  Async reset mid-transfer: all state cleared immediately, o_soft_rst deasserts.
// STRUCTURE
//  Package tlk2711_pkg: state enum (IDLE/ARM/WAIT/POST/RECOV), done-record struct
//  {idx,len,frames,err}. Sub-module tlk2711_buf_ring: table RAM, free bitmap, head pointer,
//  popcount. FSM, watchdog, soft-reset counter stay in top level.
// TESTING
//  Load 4 addrs 0x1000_0000+n*0x10_0000, enable, 4 interrupts (len 5120, frames 1) -> 4
//   o_rx_start with those addrs in order, 4 records idx 0..3, o_free_cnt 4->0, FSM holds IDLE.
//  Release idx 0 after ring full -> o_free_cnt 1, ARM at 0x1000_0000 (head wrapped to 0).
//  Loss pulse in WAIT -> o_soft_rst high exactly 16 cycles, record err=1 len=0, head advances.
//  No interrupt (TMO_W=8) -> RECOV after 255 WAIT cycles, err=1.
//  Interrupt and loss same cycle -> err=0, len latched, no o_soft_rst.
//  Hold i_done_ready=0 10 cycles -> record fields stable, no new o_rx_start; reset mid-WAIT
//   -> all outputs 0, o_free_cnt=4.

Source files
------------

// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg: shared scheduler state encoding, completion record type and popcount helper
package tlk2711_pkg;
  localparam int MAX_IDX_W = 4;
  localparam int MAX_BUF = 2 ** MAX_IDX_W;
  typedef enum logic [2:0] {IDLE, ARM, WAIT, POST, RECOV} state_t;
  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic [31:0]          len;
    logic [15:0]          frames;
    logic                 err;
  } done_rec_t;
  function automatic logic [MAX_IDX_W:0] popcount(input logic [MAX_BUF-1:0] v);
    popcount = '0;
    for (int i = 0; i < MAX_BUF; i++) popcount = popcount + {{MAX_IDX_W{1'b0}}, v[i]};
  endfunction
endpackage

// File: rtl/tlk2711_buf_ring.sv
// tlk2711_buf_ring: base-address table, free bitmap, head pointer and registered free count
//  ports: i_cfg_* table write, i_release/i_release_idx buffer return, i_claim clears free[head],
//         i_advance steps head, o_head/o_head_free/o_head_addr head view, o_free_cnt popcount
module tlk2711_buf_ring
  import tlk2711_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BUF    = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cfg_we,
  input  logic [IDX_W-1:0]      i_cfg_idx,
  input  logic [ADDR_WIDTH-1:0] i_cfg_addr,
  input  logic                  i_release,
  input  logic [IDX_W-1:0]      i_release_idx,
  input  logic                  i_claim,
  input  logic                  i_advance,
  output logic [IDX_W-1:0]      o_head,
  output logic                  o_head_free,
  output logic [ADDR_WIDTH-1:0] o_head_addr,
  output logic [IDX_W:0]        o_free_cnt
);
  logic [ADDR_WIDTH-1:0] r_tab [NUM_BUF];
  logic [NUM_BUF-1:0]    r_free;
  logic [NUM_BUF-1:0]    w_free_nxt;
  logic [IDX_W-1:0]      r_head;
  logic [IDX_W:0]        r_cnt;
  logic                  w_unused;
  assign w_unused = ^i_cfg_addr[2:0];
  // claim is applied after release so a same-index collision leaves the buffer owned
  always_comb begin
    w_free_nxt = r_free;
    if (i_release) w_free_nxt[i_release_idx] = 1'b1;
    if (i_claim) w_free_nxt[r_head] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BUF; i++) r_tab[i] <= '0;
      r_free <= '1;
      r_head <= '0;
      r_cnt  <= (IDX_W+1)'(NUM_BUF);
    end else begin
      if (i_cfg_we) r_tab[i_cfg_idx] <= {i_cfg_addr[ADDR_WIDTH-1:3], 3'b000};
      r_free <= w_free_nxt;
      if (i_advance) r_head <= r_head + 1'b1;
      r_cnt <= (IDX_W+1)'(popcount(MAX_BUF'(r_free)));
    end
  end
  assign o_head      = r_head;
  assign o_head_free = r_free[r_head];
  assign o_head_addr = r_tab[r_head];
  assign o_free_cnt  = r_cnt;
endmodule

// File: rtl/tlk2711_rx_sched.sv
// tlk2711_rx_sched: buffer-ring scheduler arming tlk2711_rx_link and posting completion records
//  ports: i_enable run enable, i_cfg_* table write, i_release* buffer return,
//         o_rx_start/o_rx_base_addr arm link, i_rx_* packet-complete info, i_loss_interrupt,
//         o_soft_rst link reset, o_done_* valid/ready completion record, o_free_cnt, o_busy
module tlk2711_rx_sched
  import tlk2711_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BUF    = 4,
  parameter int IDX_W      = 2,
  parameter int TMO_W      = 24,
  parameter int RST_CYC    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic                  i_cfg_we,
  input  logic [IDX_W-1:0]      i_cfg_idx,
  input  logic [ADDR_WIDTH-1:0] i_cfg_addr,
  input  logic                  i_release,
  input  logic [IDX_W-1:0]      i_release_idx,
  output logic                  o_rx_start,
  output logic [ADDR_WIDTH-1:0] o_rx_base_addr,
  input  logic                  i_rx_interrupt,
  input  logic [31:0]           i_rx_total_packet,
  input  logic [15:0]           i_rx_body_num,
  input  logic                  i_loss_interrupt,
  output logic                  o_soft_rst,
  output logic                  o_done_valid,
  input  logic                  i_done_ready,
  output logic [IDX_W-1:0]      o_done_idx,
  output logic [31:0]           o_done_len,
  output logic [15:0]           o_done_frames,
  output logic                  o_done_err,
  output logic [IDX_W:0]        o_free_cnt,
  output logic                  o_busy
);
  localparam int RC_W = $clog2(RST_CYC) + 1;
  state_t                r_state, w_next;
  logic [TMO_W-1:0]      r_wd;
  logic [RC_W-1:0]       r_rc;
  logic [ADDR_WIDTH-1:0] r_base;
  done_rec_t             r_rec;
  logic [IDX_W-1:0]      w_head;
  logic                  w_head_free;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic                  w_unused;
  tlk2711_buf_ring #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_BUF   (NUM_BUF),
    .IDX_W     (IDX_W)
  ) u_ring (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_we     (i_cfg_we),
    .i_cfg_idx    (i_cfg_idx),
    .i_cfg_addr   (i_cfg_addr),
    .i_release    (i_release),
    .i_release_idx(i_release_idx),
    .i_claim      (r_state == ARM),
    .i_advance    (r_state == POST && i_done_ready),
    .o_head       (w_head),
    .o_head_free  (w_head_free),
    .o_head_addr  (w_head_addr),
    .o_free_cnt   (o_free_cnt)
  );
  // packet-complete has priority over loss/timeout in the same cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (i_enable && w_head_free) ? ARM : IDLE;
      ARM:     w_next = i_loss_interrupt ? RECOV : WAIT;
      WAIT:    w_next = i_rx_interrupt ? POST : (i_loss_interrupt || &r_wd) ? RECOV : WAIT;
      RECOV:   w_next = (r_rc == RC_W'(RST_CYC - 1)) ? POST : RECOV;
      POST:    w_next = i_done_ready ? IDLE : POST;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wd    <= '0;
      r_rc    <= '0;
      r_base  <= '0;
      r_rec   <= '0;
    end else begin
      r_state <= w_next;
      r_wd    <= (r_state == WAIT) ? r_wd + 1'b1 : '0;
      r_rc    <= (r_state == RECOV) ? r_rc + 1'b1 : '0;
      // latch the address on the way into ARM so it is valid alongside o_rx_start
      if (r_state == IDLE && w_next == ARM) r_base <= w_head_addr;
      if (r_state == WAIT && i_rx_interrupt)
        r_rec <= '{idx: MAX_IDX_W'(w_head), len: i_rx_total_packet, frames: i_rx_body_num, err: 1'b0};
      else if (r_state != RECOV && w_next == RECOV)
        r_rec <= '{idx: MAX_IDX_W'(w_head), len: '0, frames: '0, err: 1'b1};
    end
  end
  assign w_unused       = ^r_rec.idx;
  assign o_rx_start     = r_state == ARM;
  assign o_rx_base_addr = r_base;
  assign o_soft_rst     = r_state == RECOV;
  assign o_done_valid   = r_state == POST;
  assign o_done_idx     = r_rec.idx[IDX_W-1:0];
  assign o_done_len     = r_rec.len;
  assign o_done_frames  = r_rec.frames;
  assign o_done_err     = r_rec.err;
  assign o_busy         = r_state != IDLE;
endmodule

// File: tb/tb_tlk2711_rx_sched.sv
// tb_tlk2711_rx_sched: directed-plus-random bench for tlk2711_rx_sched against a ring model
module tb_tlk2711_rx_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_cfg_we = 1'b0;
  logic [1:0]  i_cfg_idx = '0;
  logic [31:0] i_cfg_addr = '0;
  logic        i_release = 1'b0;
  logic [1:0]  i_release_idx = '0;
  logic        o_rx_start;
  logic [31:0] o_rx_base_addr;
  logic        i_rx_interrupt = 1'b0;
  logic [31:0] i_rx_total_packet = '0;
  logic [15:0] i_rx_body_num = '0;
  logic        i_loss_interrupt = 1'b0;
  logic        o_soft_rst;
  logic        o_done_valid;
  logic        i_done_ready = 1'b0;
  logic [1:0]  o_done_idx;
  logic [31:0] o_done_len;
  logic [15:0] o_done_frames;
  logic        o_done_err;
  logic [2:0]  o_free_cnt;
  logic        o_busy;

  always #5 clk = ~clk;

  tlk2711_rx_sched #(
    .ADDR_WIDTH(32), .NUM_BUF(4), .IDX_W(2), .TMO_W(8), .RST_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx), .i_cfg_addr(i_cfg_addr),
    .i_release(i_release), .i_release_idx(i_release_idx),
    .o_rx_start(o_rx_start), .o_rx_base_addr(o_rx_base_addr),
    .i_rx_interrupt(i_rx_interrupt), .i_rx_total_packet(i_rx_total_packet),
    .i_rx_body_num(i_rx_body_num), .i_loss_interrupt(i_loss_interrupt),
    .o_soft_rst(o_soft_rst), .o_done_valid(o_done_valid), .i_done_ready(i_done_ready),
    .o_done_idx(o_done_idx), .o_done_len(o_done_len), .o_done_frames(o_done_frames),
    .o_done_err(o_done_err), .o_free_cnt(o_free_cnt), .o_busy(o_busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_tab [4];
  bit          m_free [4];
  int          m_head;

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(m_free[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_tab[i] = '0;
      m_free[i] = 1'b1;
    end
    m_head = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int idx, input logic [31:0] addr);
    i_cfg_we = 1'b1;
    i_cfg_idx = 2'(idx);
    i_cfg_addr = addr;
    step();
    i_cfg_we = 1'b0;
    m_tab[idx] = {addr[31:3], 3'b000};
  endtask

  task automatic release_buf(input int idx);
    i_release = 1'b1;
    i_release_idx = 2'(idx);
    step();
    i_release = 1'b0;
    m_free[idx] = 1'b1;
  endtask

  // finds the arm pulse, checks its address, and leaves the DUT one cycle later in WAIT
  task automatic wait_start();
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (o_rx_start) found = 1;
      else step();
    end
    chk("rx_start_seen", 64'(found), 1);
    if (found) begin
      chk("rx_base_addr", o_rx_base_addr, m_tab[m_head]);
      m_free[m_head] = 1'b0;
      step();
      chk("rx_start_one_cycle", o_rx_start, 0);
    end
  endtask

  task automatic expect_rec(input int idx, input logic [31:0] len, input logic [15:0] fr,
                            input bit err);
    chk("done_valid", o_done_valid, 1);
    chk("done_idx", o_done_idx, 64'(idx));
    chk("done_len", o_done_len, len);
    chk("done_frames", o_done_frames, fr);
    chk("done_err", o_done_err, err);
  endtask

  task automatic handshake();
    repeat ($urandom_range(0, 3)) begin
      step();
      chk("done_valid_hold", o_done_valid, 1);
    end
    i_done_ready = 1'b1;
    step();
    i_done_ready = 1'b0;
    chk("done_valid_drop", o_done_valid, 0);
    m_head = (m_head + 1) % 4;
  endtask

  task automatic good_packet(input logic [31:0] len, input logic [15:0] fr);
    wait_start();
    repeat ($urandom_range(0, 5)) step();
    i_rx_total_packet = len;
    i_rx_body_num = fr;
    i_rx_interrupt = 1'b1;
    step();
    i_rx_interrupt = 1'b0;
    i_rx_total_packet = $urandom;
    i_rx_body_num = 16'($urandom);
    expect_rec(m_head, len, fr, 0);
    chk("free_cnt_post", o_free_cnt, 64'(m_cnt()));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          soft_cyc;
    bit          any_start;
    logic [31:0] len;
    logic [15:0] fr;
    logic [31:0] old_addr;
    m_reset();
    repeat (3) step();
    chk("rst_rx_start", o_rx_start, 0);
    chk("rst_base_addr", o_rx_base_addr, 0);
    chk("rst_soft_rst", o_soft_rst, 0);
    chk("rst_done_valid", o_done_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_free_cnt", o_free_cnt, 4);
    rst_n = 1'b1;
    step();
    for (int n = 0; n < 4; n++) cfg(n, 32'h1000_0000 + n * 32'h10_0000 + ($urandom & 7));
    chk("idle_no_enable", o_busy, 0);
    i_enable = 1'b1;
    for (int n = 0; n < 4; n++) begin
      len = (n == 0) ? 32'd5120 : $urandom;
      fr = (n == 0) ? 16'd1 : 16'($urandom);
      good_packet(len, fr);
      handshake();
    end
    any_start = 0;
    repeat (10) begin
      step();
      any_start |= o_rx_start;
    end
    chk("full_no_start", 64'(any_start), 0);
    chk("full_busy", o_busy, 0);
    chk("full_free_cnt", o_free_cnt, 0);
    release_buf(0);
    step();
    chk("release_free_cnt", o_free_cnt, 1);
    good_packet($urandom, 16'($urandom));
    handshake();
    i_enable = 1'b0;
    release_buf(1);
    release_buf(2);
    release_buf(3);
    release_buf(2);
    repeat (2) step();
    chk("release_dup_cnt", o_free_cnt, 64'(m_cnt()));
    chk("disabled_idle", o_busy, 0);
    i_enable = 1'b1;
    wait_start();
    repeat ($urandom_range(0, 5)) step();
    i_rx_total_packet = $urandom | 32'h1;
    i_loss_interrupt = 1'b1;
    step();
    i_loss_interrupt = 1'b0;
    soft_cyc = 0;
    for (int i = 0; i < 40 && !o_done_valid; i++) begin
      soft_cyc += int'(o_soft_rst);
      step();
    end
    chk("loss_soft_rst_len", 64'(soft_cyc), 16);
    chk("loss_soft_rst_off", o_soft_rst, 0);
    expect_rec(m_head, 0, 0, 1);
    handshake();
    wait_start();
    len = $urandom;
    fr = 16'($urandom);
    i_rx_total_packet = len;
    i_rx_body_num = fr;
    i_rx_interrupt = 1'b1;
    i_loss_interrupt = 1'b1;
    step();
    i_rx_interrupt = 1'b0;
    i_loss_interrupt = 1'b0;
    chk("both_no_soft_rst", o_soft_rst, 0);
    expect_rec(m_head, len, fr, 0);
    handshake();
    wait_start();
    cyc = 0;
    while (!o_soft_rst && cyc < 400) begin
      step();
      cyc++;
    end
    chk("timeout_window", 64'(cyc >= 255 && cyc <= 256), 1);
    for (int i = 0; i < 20 && !o_done_valid; i++) step();
    expect_rec(m_head, 0, 0, 1);
    handshake();
    release_buf(0);
    wait_start();
    old_addr = m_tab[0];
    cfg(0, $urandom);
    chk("cfg_during_wait", o_rx_base_addr, old_addr);
    len = $urandom;
    fr = 16'($urandom);
    i_rx_total_packet = len;
    i_rx_body_num = fr;
    i_rx_interrupt = 1'b1;
    step();
    i_rx_interrupt = 1'b0;
    release_buf(1);
    any_start = 0;
    for (int i = 0; i < 10; i++) begin
      any_start |= o_rx_start;
      chk("hold_len", o_done_len, len);
      chk("hold_frames", o_done_frames, fr);
      chk("hold_idx", o_done_idx, 64'(m_head));
      step();
    end
    chk("hold_no_start", 64'(any_start), 0);
    expect_rec(m_head, len, fr, 0);
    handshake();
    wait_start();
    chk("reset_pre_busy", o_busy, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_busy", o_busy, 0);
    chk("arst_rx_start", o_rx_start, 0);
    chk("arst_base_addr", o_rx_base_addr, 0);
    chk("arst_soft_rst", o_soft_rst, 0);
    chk("arst_done_valid", o_done_valid, 0);
    chk("arst_free_cnt", o_free_cnt, 64'(m_cnt()));
    repeat (2) step();
    rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
